// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the DMEM port arbiter: FSM state codes, owner codes,
// the per-side DMEM command bundle and the starvation counter helper.
package dmem_arbiter_pkg;

  localparam logic [0:0] S_CPU = 1'b0;
  localparam logic [0:0] S_EXT = 1'b1;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_EXT  = 2'd2;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_EXT  = 2'd2
  } gnt_e;

  typedef struct packed {
    logic        wena;
    logic [1:0]  wsel;
    logic [1:0]  rsel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_cmd_t;

  localparam dmem_cmd_t DMEM_CMD_IDLE = '{
    wena:  1'b0,
    wsel:  2'd0,
    rsel:  2'd0,
    addr:  32'd0,
    wdata: 32'd0
  };

  // Saturating increment of the 4-bit starvation counter.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
    logic [3:0] r;
    if (v >= lim) begin
      r = lim;
    end else begin
      r = v + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the single DMEM port between the CPU MEM stage (fixed priority)
// and an external loader/DMA, with a starvation bound and bounded locked bursts.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int BURST_MAX  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_wena,
  input  logic [1:0]  cpu_wsel,
  input  logic [1:0]  cpu_rsel,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        ext_req,
  input  logic        ext_lock,
  input  logic        ext_wena,
  input  logic [1:0]  ext_wsel,
  input  logic [1:0]  ext_rsel,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_gnt,
  output logic [31:0] ext_rdata,
  output logic        dmem_ena,
  output logic        dmem_wena,
  output logic [1:0]  dmem_wsel,
  output logic [1:0]  dmem_rsel,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  output logic [1:0]  owner
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);
  localparam logic       BURST_EN   = (BURST_MAX > 1) ? 1'b1 : 1'b0;

  logic [0:0] r_state;
  logic [3:0] r_starve_cnt;
  logic [7:0] r_beat_cnt;

  logic [0:0] w_state_nxt;
  logic [3:0] w_starve_nxt;
  logic [7:0] w_beat_nxt;
  logic [3:0] w_starve_eff;
  logic       w_burst_beat;
  gnt_e       w_gnt;
  dmem_cmd_t  w_cmd_cpu;
  dmem_cmd_t  w_cmd_ext;
  dmem_cmd_t  w_cmd_sel;

  assign w_cmd_cpu = '{wena: cpu_wena, wsel: cpu_wsel, rsel: cpu_rsel,
                       addr: cpu_addr, wdata: cpu_wdata};
  assign w_cmd_ext = '{wena: ext_wena, wsel: ext_wsel, rsel: ext_rsel,
                       addr: ext_addr, wdata: ext_wdata};

  // A burst abort re-arbitrates as if the CPU had not been waiting.
  assign w_starve_eff = (r_state == S_EXT) ? 4'd0 : r_starve_cnt;
  assign w_burst_beat = (r_state == S_EXT) && ext_req;

  // Grant decision for the current cycle; reset suppresses every grant.
  always_comb begin
    w_gnt = GNT_NONE;
    if (rst) begin
      w_gnt = GNT_NONE;
    end else if (w_burst_beat) begin
      w_gnt = GNT_EXT;
    end else if (ext_req && (!cpu_req || (w_starve_eff == STARVE_LIM))) begin
      w_gnt = GNT_EXT;
    end else if (cpu_req) begin
      w_gnt = GNT_CPU;
    end else begin
      w_gnt = GNT_NONE;
    end
  end

  // Next-state, starvation and beat counter computation.
  always_comb begin
    w_state_nxt  = S_CPU;
    w_starve_nxt = 4'd0;
    w_beat_nxt   = 8'd0;
    if (w_burst_beat) begin
      w_beat_nxt = r_beat_cnt + 8'd1;
      if (!ext_lock || (r_beat_cnt == BURST_LAST)) begin
        w_state_nxt = S_CPU;
        w_beat_nxt  = 8'd0;
      end else begin
        w_state_nxt = S_EXT;
      end
    end else begin
      case (w_gnt)
        GNT_EXT: begin
          if (ext_lock && BURST_EN) begin
            w_state_nxt = S_EXT;
            w_beat_nxt  = 8'd1;
          end else begin
            w_state_nxt = S_CPU;
          end
        end
        GNT_CPU: begin
          if (ext_req) begin
            w_starve_nxt = sat_inc4(w_starve_eff, STARVE_LIM);
          end else begin
            w_starve_nxt = 4'd0;
          end
        end
        default: begin
          w_state_nxt  = S_CPU;
          w_starve_nxt = 4'd0;
        end
      endcase
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_CPU;
      r_starve_cnt <= 4'd0;
      r_beat_cnt   <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_beat_cnt   <= w_beat_nxt;
    end
  end

  // Steer the granted side onto the DMEM port and report ownership.
  always_comb begin
    w_cmd_sel = DMEM_CMD_IDLE;
    owner     = OWN_NONE;
    case (w_gnt)
      GNT_CPU: begin
        w_cmd_sel = w_cmd_cpu;
        owner     = OWN_CPU;
      end
      GNT_EXT: begin
        w_cmd_sel = w_cmd_ext;
        owner     = OWN_EXT;
      end
      default: begin
        w_cmd_sel = DMEM_CMD_IDLE;
        owner     = OWN_NONE;
      end
    endcase
  end

  assign dmem_ena   = (w_gnt != GNT_NONE);
  assign dmem_wena  = dmem_ena && w_cmd_sel.wena;
  assign dmem_wsel  = w_cmd_sel.wsel;
  assign dmem_rsel  = w_cmd_sel.rsel;
  assign dmem_addr  = w_cmd_sel.addr;
  assign dmem_wdata = w_cmd_sel.wdata;

  assign cpu_rdata = dmem_rdata;
  assign ext_rdata = dmem_rdata;
  assign cpu_stall = !rst && cpu_req && (w_gnt != GNT_CPU);
  assign ext_gnt   = ext_req && (w_gnt == GNT_EXT);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural word-wide DMEM.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_wena;
  logic [1:0]  cpu_wsel, cpu_rsel;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ext_req, ext_lock, ext_wena;
  logic [1:0]  ext_wsel, ext_rsel;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        ext_gnt;
  logic        dmem_ena, dmem_wena;
  logic [1:0]  dmem_wsel, dmem_rsel;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [1:0]  owner;

  logic [31:0] mem [0:255];
  logic        mem_clr;
  int          total = 0;
  int          bad = 0;

  dmem_arbiter #(.STARVE_MAX(4), .BURST_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wena(cpu_wena), .cpu_wsel(cpu_wsel), .cpu_rsel(cpu_rsel),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_lock(ext_lock), .ext_wena(ext_wena), .ext_wsel(ext_wsel),
    .ext_rsel(ext_rsel), .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_gnt(ext_gnt),
    .ext_rdata(ext_rdata), .dmem_ena(dmem_ena), .dmem_wena(dmem_wena), .dmem_wsel(dmem_wsel),
    .dmem_rsel(dmem_rsel), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  // Word-wide DMEM model: combinational read, write at the rising edge.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
    end else if (dmem_ena && dmem_wena) begin
      mem[dmem_addr[9:2]] <= dmem_wdata;
    end
  end
  assign dmem_rdata = mem[dmem_addr[9:2]];

  task automatic drive_idle();
    cpu_req = 1'b0; cpu_wena = 1'b0; cpu_wsel = 2'd2; cpu_rsel = 2'd2;
    cpu_addr = 32'd0; cpu_wdata = 32'd0;
    ext_req = 1'b0; ext_lock = 1'b0; ext_wena = 1'b0; ext_wsel = 2'd2; ext_rsel = 2'd2;
    ext_addr = 32'd0; ext_wdata = 32'd0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; cpu_req = 1'b1; cpu_wena = 1'b1; ext_req = 1'b1; ext_wena = 1'b1;
    #1;
    total++; if (dmem_ena !== 1'b0) begin bad++; $display("FAIL reset_ena got=%0b exp=0", dmem_ena); end
    total++; if (dmem_wena !== 1'b0) begin bad++; $display("FAIL reset_wena got=%0b exp=0", dmem_wena); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", cpu_stall); end
    total++; if (ext_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt got=%0b exp=0", ext_gnt); end
    total++; if (owner !== 2'd0) begin bad++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    @(negedge clk);
    rst = 1'b0; mem_clr = 1'b0; drive_idle();
  endtask

  task automatic test_cpu_only();
    @(negedge clk);
    cpu_req = 1'b1; cpu_wena = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    #1;
    total++; if (owner !== 2'd1) begin bad++; $display("FAIL cpu_st_owner got=%0d exp=1", owner); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL cpu_st_stall got=%0b exp=0", cpu_stall); end
    total++; if (dmem_wena !== 1'b1 || dmem_addr !== 32'h10 || dmem_wdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL cpu_st_bus got wena=%0b addr=%h data=%h exp 1/10/deadbeef", dmem_wena, dmem_addr, dmem_wdata); end
    @(negedge clk);
    cpu_wena = 1'b0; cpu_wdata = 32'd0;
    #1;
    total++; if (owner !== 2'd1) begin bad++; $display("FAIL cpu_ld_owner got=%0d exp=1", owner); end
    total++; if (dmem_wena !== 1'b0) begin bad++; $display("FAIL cpu_ld_wena got=%0b exp=0", dmem_wena); end
    total++; if (cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL cpu_ld_rdata got=%h exp=deadbeef", cpu_rdata); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_starvation();
    logic exp_ext;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_addr = 32'h10;
      ext_req = 1'b1; ext_lock = 1'b0; ext_addr = 32'h10;
      #1;
      exp_ext = ((c % 5) == 4);
      total++; if (ext_gnt !== exp_ext) begin bad++; $display("FAIL starve_gnt c=%0d got=%0b exp=%0b", c, ext_gnt, exp_ext); end
      total++; if (cpu_stall !== exp_ext) begin bad++; $display("FAIL starve_stall c=%0d got=%0b exp=%0b", c, cpu_stall, exp_ext); end
      total++; if (owner !== (exp_ext ? 2'd2 : 2'd1)) begin bad++; $display("FAIL starve_owner c=%0d got=%0d exp=%0d", c, owner, exp_ext ? 2 : 1); end
      if (exp_ext) begin
        total++; if (ext_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL starve_rdata c=%0d got=%h exp=deadbeef", c, ext_rdata); end
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_locked_burst();
    int  b;
    logic exp_ext;
    b = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      cpu_req = (c != 0); cpu_addr = 32'h10;
      ext_req = (b < 10); ext_lock = ((10 - b) > 1); ext_wena = 1'b1;
      ext_addr = 32'h100 + 32'(4 * b); ext_wdata = 32'hA000_0000 + 32'(b);
      #1;
      exp_ext = (c < 8) || (c == 12) || (c == 13);
      total++; if (ext_gnt !== exp_ext) begin bad++; $display("FAIL burst_gnt c=%0d got=%0b exp=%0b", c, ext_gnt, exp_ext); end
      total++; if (cpu_stall !== (cpu_req && exp_ext)) begin bad++; $display("FAIL burst_stall c=%0d got=%0b exp=%0b", c, cpu_stall, cpu_req && exp_ext); end
      if (exp_ext) b++;
    end
    @(negedge clk);
    drive_idle();
    for (int k = 0; k < 10; k++) begin
      total++; if (mem[64 + k] !== 32'hA000_0000 + 32'(k)) begin
        bad++; $display("FAIL burst_mem k=%0d got=%h exp=%h", k, mem[64 + k], 32'hA000_0000 + 32'(k)); end
    end
  endtask

  task automatic test_burst_abort();
    @(negedge clk);
    ext_req = 1'b1; ext_lock = 1'b1; ext_addr = 32'h10;
    #1;
    total++; if (ext_gnt !== 1'b1) begin bad++; $display("FAIL abort_b1 got=%0b exp=1", ext_gnt); end
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 32'h10;
    #1;
    total++; if (ext_gnt !== 1'b1 || cpu_stall !== 1'b1) begin bad++; $display("FAIL abort_b2 got gnt=%0b stall=%0b exp 1/1", ext_gnt, cpu_stall); end
    @(negedge clk);
    ext_req = 1'b0;
    #1;
    total++; if (owner !== 2'd1 || cpu_stall !== 1'b0) begin bad++; $display("FAIL abort_cpu got owner=%0d stall=%0b exp 1/0", owner, cpu_stall); end
    @(negedge clk);
    ext_req = 1'b1; ext_lock = 1'b0;
    #1;
    total++; if (owner !== 2'd1 || ext_gnt !== 1'b0) begin bad++; $display("FAIL abort_state got owner=%0d gnt=%0b exp 1/0", owner, ext_gnt); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_reset_mid_burst();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rst = (c == 3);
      ext_req = 1'b1; ext_lock = 1'b1; ext_wena = 1'b1;
      ext_addr = 32'h200 + 32'(4 * c); ext_wdata = 32'hB000_0000 + 32'(c);
      #1;
      if (c == 3) begin
        total++; if (dmem_wena !== 1'b0 || dmem_ena !== 1'b0) begin bad++; $display("FAIL rstmid_bus got ena=%0b wena=%0b exp 0/0", dmem_ena, dmem_wena); end
        total++; if (ext_gnt !== 1'b0) begin bad++; $display("FAIL rstmid_gnt got=%0b exp=0", ext_gnt); end
      end else begin
        total++; if (ext_gnt !== 1'b1) begin bad++; $display("FAIL rstmid_beat c=%0d got=%0b exp=1", c, ext_gnt); end
      end
    end
    @(negedge clk);
    rst = 1'b0; drive_idle();
    #1;
    total++; if (dut.r_state !== 1'b0) begin bad++; $display("FAIL rstmid_state got=%0d exp=0", dut.r_state); end
    total++; if (dut.r_starve_cnt !== 4'd0) begin bad++; $display("FAIL rstmid_starve got=%0d exp=0", dut.r_starve_cnt); end
    for (int k = 0; k < 4; k++) begin
      total++; if (mem[128 + k] !== ((k < 3) ? 32'hB000_0000 + 32'(k) : 32'd0)) begin
        bad++; $display("FAIL rstmid_mem k=%0d got=%h", k, mem[128 + k]); end
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_idle();
      #1;
      total++; if (dmem_ena !== 1'b0 || owner !== 2'd0) begin bad++; $display("FAIL idle c=%0d got ena=%0b owner=%0d exp 0/0", c, dmem_ena, owner); end
      total++; if (dut.r_starve_cnt !== 4'd0) begin bad++; $display("FAIL idle_starve c=%0d got=%0d exp=0", c, dut.r_starve_cnt); end
    end
  endtask

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    drive_idle();
    test_reset();
    test_cpu_only();
    test_starvation();
    test_locked_burst();
    test_burst_abort();
    test_reset_mid_burst();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
